// File: rtl/snake_matrix_driver.sv
// Row-scanning renderer for a 16x16 two-colour LED matrix fed by the snake core.
// Optional food blinking is enabled by defining SNAKE_RENDER_BLINK_EN.
module snake_matrix_driver #(
   parameter int ROW_CYCLES   = 1000,
   parameter int BLINK_FRAMES = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [7:0]   Food,
   input  logic [3:0]   Length,
   input  logic [127:0] Locations_Flat,
   output logic [15:0]  Row_Sel,
   output logic [15:0]  Col_Head,
   output logic [15:0]  Col_Snake,
   output logic [15:0]  Col_Food,
   output logic         Frame_Start
);

   typedef enum logic [1:0] {SNAP, BUILD, SHOW} state_t;

   localparam logic [15:0] DWELL_LAST = 16'(ROW_CYCLES - 1);

   state_t      state, state_nx;
   logic [7:0]  food_s;
   logic [3:0]  len_s;
   logic [7:0]  loc_s [16];
   logic [3:0]  row;
   logic [3:0]  seg;
   logic [15:0] dwell;
   logic [15:0] head_b, snake_b, food_b;
   logic        phase;
   logic        dwell_done;

   assign dwell_done = (dwell == DWELL_LAST);

   always_comb begin
      state_nx    = state;
      Row_Sel     = '0;
      Col_Head    = '0;
      Col_Snake   = '0;
      Col_Food    = '0;
      Frame_Start = 1'b0;
      case (state)
         SNAP: begin
            // The snapshot edge only happens when reset is released.
            Frame_Start = Reset;
            state_nx    = BUILD;
         end
         BUILD: begin
            if (seg == 4'd15) state_nx = SHOW;
         end
         SHOW: begin
            Row_Sel   = 16'd1 << row;
            Col_Head  = head_b;
            Col_Snake = snake_b;
            Col_Food  = phase ? 16'd0 : food_b;
            if (dwell_done) state_nx = (row == 4'd15) ? SNAP : BUILD;
         end
         default: state_nx = SNAP;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state   <= SNAP;
         row     <= '0;
         seg     <= '0;
         dwell   <= '0;
         food_s  <= '0;
         len_s   <= '0;
         head_b  <= '0;
         snake_b <= '0;
         food_b  <= '0;
         for (int k = 0; k < 16; k++) loc_s[k] <= '0;
      end else begin
         state <= state_nx;
         case (state)
            SNAP: begin
               food_s  <= Food;
               len_s   <= Length;
               for (int k = 0; k < 16; k++) loc_s[k] <= Locations_Flat[127-8*k -: 8];
               row     <= '0;
               seg     <= '0;
               dwell   <= '0;
               head_b  <= '0;
               snake_b <= '0;
               food_b  <= '0;
            end
            BUILD: begin
               // One segment slot per cycle; slots beyond the length are ignored.
               seg   <= seg + 4'd1;
               dwell <= '0;
               if (seg <= len_s && loc_s[seg][7:4] == row) begin
                  if (seg == 4'd0) head_b[loc_s[seg][3:0]]  <= 1'b1;
                  else             snake_b[loc_s[seg][3:0]] <= 1'b1;
               end
               if (seg == 4'd0 && food_s[7:4] == row) food_b[food_s[3:0]] <= 1'b1;
            end
            SHOW: begin
               if (dwell_done) begin
                  dwell   <= '0;
                  head_b  <= '0;
                  snake_b <= '0;
                  food_b  <= '0;
                  if (row != 4'd15) row <= row + 4'd1;
               end else begin
                  dwell <= dwell + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SNAKE_RENDER_BLINK_EN
   logic [7:0] frame_cnt;

   // frame_cnt holds the number of frames already started in the current phase.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (state == SNAP) begin
         if (frame_cnt == 8'(BLINK_FRAMES)) begin
            phase     <= ~phase;
            frame_cnt <= 8'd1;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end
`else
   // No blinking: BLINK_FRAMES is at least 1, so the phase is tied to 0.
   assign phase = (BLINK_FRAMES < 1);
`endif

endmodule
